waveform_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timer. Consumes hPix/vPix/isActive/HS/VS and produces 8-bit RGB (3:3:2) plus delay-matched sync.
- Captures 640 audio samples into a double-buffered line store and draws them as an oscilloscope trace, one sample per column.
- Bank swap is frame-synchronous, so the trace never tears.

---
 rtl/waveform_renderer_if.sv | 25 ++
 rtl/waveform_renderer.sv | 150 +++++++++++++++
 tb/tb_waveform_renderer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/waveform_renderer_if.sv
// Pixel-stage bus: timer/audio inputs toward the renderer, colour and sync back out.
interface waveform_renderer_if;
  logic [7:0] sample_in;
  logic       sample_valid;
  logic [9:0] hPix;
  logic [8:0] vPix;
  logic       isActive;
  logic       HS;
  logic       VS;
  logic [7:0] rgb;
  logic       HS_out;
  logic       VS_out;
  logic       dropped;
  logic       swapped;

  modport master (
    output sample_in, sample_valid, hPix, vPix, isActive, HS, VS,
    input  rgb, HS_out, VS_out, dropped, swapped
  );

  modport slave (
    input  sample_in, sample_valid, hPix, vPix, isActive, HS, VS,
    output rgb, HS_out, VS_out, dropped, swapped
  );
endinterface

// File: rtl/waveform_renderer.sv
// Oscilloscope pixel stage: double-buffered 640-sample capture, frame-synchronous bank swap,
// 2-cycle read pipeline. Define WAVEFORM_RENDERER_FILL_EN to join adjacent columns into a line.
module waveform_renderer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter logic [7:0]  TRACE_RGB = 8'h1C,
  parameter logic [7:0]  AXIS_RGB  = 8'h49
) (
  input logic                clk,
  input logic                rst,
  waveform_renderer_if.slave bus
);
  localparam int unsigned    AW       = 10;
  localparam int unsigned    RW       = 9;
  localparam logic [AW-1:0]  LAST_COL = AW'(H_ACTIVE - 1);
  localparam logic [RW-1:0]  AXIS_ROW = RW'(V_ACTIVE / 2);
  localparam logic [RW-1:0]  ROW_BASE = RW'(V_ACTIVE / 2 + 127);

  logic [7:0]    r_bank0 [H_ACTIVE];
  logic [7:0]    r_bank1 [H_ACTIVE];
  logic [AW-1:0] r_wr_ptr;
  logic          r_front_sel, r_back_full, r_front_valid;
  logic          r_dropped, r_swapped;
  logic [7:0]    r_rd_data;
  logic [RW-1:0] r_vpix_d1;
  logic          r_act_d1, r_hs_d1, r_vs_d1, r_col0_d1;
  logic [7:0]    r_rgb;
  logic          r_hs_d2, r_vs_d2;

  logic          w_swap, w_we, w_wsel, w_hit;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [RW-1:0] w_trace_row;
  logic [7:0]    w_rgb;

  // r_vs_d1 doubles as the registered VS used for falling-edge detection
  assign w_swap  = r_vs_d1 & ~bus.VS & r_back_full;
  assign w_raddr = (bus.hPix <= LAST_COL) ? bus.hPix : '0;

  // Write port: a swap redirects a coincident sample to address 0 of the new back bank
  always_comb begin
    w_we    = 1'b0;
    w_wsel  = ~r_front_sel;
    w_waddr = r_wr_ptr;
    if (w_swap) begin
      w_we    = bus.sample_valid;
      w_wsel  = r_front_sel;
      w_waddr = '0;
    end else if (bus.sample_valid && !r_back_full) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      if (w_wsel) r_bank1[w_waddr] <= bus.sample_in;
      else        r_bank0[w_waddr] <= bus.sample_in;
    end
    r_rd_data <= r_front_sel ? r_bank1[w_raddr] : r_bank0[w_raddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_front_sel   <= 1'b0;
      r_back_full   <= 1'b0;
      r_front_valid <= 1'b0;
      r_dropped     <= 1'b0;
      r_swapped     <= 1'b0;
    end else begin
      r_swapped <= w_swap;
      r_dropped <= bus.sample_valid & r_back_full & ~w_swap;
      if (w_swap) begin
        r_front_sel   <= ~r_front_sel;
        r_front_valid <= 1'b1;
        r_back_full   <= 1'b0;
        r_wr_ptr      <= bus.sample_valid ? AW'(1) : '0;
      end else if (bus.sample_valid && !r_back_full) begin
        if (r_wr_ptr == LAST_COL) r_back_full <= 1'b1;
        else                      r_wr_ptr    <= r_wr_ptr + AW'(1);
      end
    end
  end

  // Stage 1: timer signals travel alongside the RAM read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpix_d1 <= '0;
      r_act_d1  <= 1'b0;
      r_hs_d1   <= 1'b1;
      r_vs_d1   <= 1'b1;
      r_col0_d1 <= 1'b0;
    end else begin
      r_vpix_d1 <= bus.vPix;
      r_act_d1  <= bus.isActive;
      r_hs_d1   <= bus.HS;
      r_vs_d1   <= bus.VS;
      r_col0_d1 <= (bus.hPix == '0);
    end
  end

`ifdef WAVEFORM_RENDERER_FILL_EN
  logic [RW-1:0] r_prev_row;
  logic [RW-1:0] w_prev, w_lo, w_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prev_row <= '0;
    else     r_prev_row <= w_trace_row;
  end

  // Span between this column's row and the previous one; column 0 has no predecessor
  always_comb begin
    w_prev = r_col0_d1 ? w_trace_row : r_prev_row;
    w_lo   = (w_prev < w_trace_row) ? w_prev : w_trace_row;
    w_hi   = (w_prev < w_trace_row) ? w_trace_row : w_prev;
    w_hit  = (r_vpix_d1 >= w_lo) && (r_vpix_d1 <= w_hi);
  end
`else
  always_comb begin
    w_hit = (r_vpix_d1 == w_trace_row);
  end
`endif

  // Stage 2: sample 255 -> row 112, 0 -> row 367
  assign w_trace_row = ROW_BASE - RW'(r_rd_data);

  always_comb begin
    w_rgb = '0;
    if (!r_act_d1)                    w_rgb = '0;
    else if (r_front_valid && w_hit)  w_rgb = TRACE_RGB;
    else if (r_vpix_d1 == AXIS_ROW)   w_rgb = AXIS_RGB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb   <= '0;
      r_hs_d2 <= 1'b1;
      r_vs_d2 <= 1'b1;
    end else begin
      r_rgb   <= w_rgb;
      r_hs_d2 <= r_hs_d1;
      r_vs_d2 <= r_vs_d1;
    end
  end

  assign bus.rgb     = r_rgb;
  assign bus.HS_out  = r_hs_d2;
  assign bus.VS_out  = r_vs_d2;
  assign bus.dropped = r_dropped;
  assign bus.swapped = r_swapped;
endmodule

// File: tb/tb_waveform_renderer.sv
// Scoreboard bench for waveform_renderer: compressed frames scanning selected rows.
module tb_waveform_renderer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  waveform_renderer_if bus ();

  waveform_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_drop = 0;
  int unsigned n_swap = 0;

  logic [9:0] q_vid [$];
  logic [1:0] q_evt [$];

  logic [7:0] m_front [640];
  logic [7:0] m_back  [640];
  int         m_wr;
  bit         m_full, m_fvalid, m_prev_vs;

  int         scan_rows [8] = '{0, 112, 239, 240, 241, 300, 367, 479};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int row_of(input logic [7:0] s);
    return 367 - int'(s);
  endfunction

  task automatic model_reset();
    m_wr = 0; m_full = 1'b0; m_fvalid = 1'b0; m_prev_vs = 1'b1;
  endtask

  // One pixel clock of stimulus; expectations are queued before the model advances
  task automatic step(input int h, input int v, input bit act, input bit hs, input bit vs,
                      input bit sv, input logic [7:0] s);
    logic [7:0] rgb;
    bit         lit, swp, drp;
    int         tr, pr, lo, hi;
    @(negedge clk);
    bus.hPix = 10'(h); bus.vPix = 9'(v); bus.isActive = act;
    bus.HS = hs; bus.VS = vs; bus.sample_valid = sv; bus.sample_in = s;
    rgb = 8'h00;
    if (act) begin
      tr = row_of(m_front[h]);
`ifdef WAVEFORM_RENDERER_FILL_EN
      pr = (h == 0) ? tr : row_of(m_front[h-1]);
`else
      pr = tr;
`endif
      lo  = (pr < tr) ? pr : tr;
      hi  = (pr < tr) ? tr : pr;
      lit = (v >= lo) && (v <= hi);
      if (m_fvalid && lit) rgb = 8'h1C;
      else if (v == 240)   rgb = 8'h49;
    end
    q_vid.push_back({rgb, hs, vs});
    swp = m_prev_vs && !vs && m_full;
    drp = sv && m_full && !swp;
    q_evt.push_back({drp, swp});
    m_prev_vs = vs;
    if (swp) begin
      m_front  = m_back;
      m_fvalid = 1'b1;
      m_full   = 1'b0;
      m_wr     = 0;
      if (sv) begin m_back[0] = s; m_wr = 1; end
    end else if (sv && !m_full) begin
      m_back[m_wr] = s;
      if (m_wr == 639) m_full = 1'b1;
      else             m_wr++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(700, 490, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  // mode 0: constant 128, 1: ramp, 2: random
  task automatic feed(input int n, input int mode);
    logic [7:0] s;
    for (int i = 0; i < n; i++) begin
      s = (mode == 0) ? 8'd128 : (mode == 1) ? 8'(i) : 8'($urandom_range(0, 255));
      step(700, 490, 1'b0, 1'b1, 1'b1, 1'b1, s);
    end
  endtask

  task automatic line(input int r, input int ncols);
    for (int h = 0; h < ncols; h++) step(h, r, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    if (ncols == 640)
      for (int h = 640; h < 648; h++)
        step(h, r, 1'b0, !(h >= 642 && h < 646), 1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame(input int nlines, input bit sv_fall, input logic [7:0] s);
    idle(4);
    step(700, 490, 1'b0, 1'b1, 1'b0, sv_fall, s);
    for (int i = 0; i < 2; i++) step(700, 491, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);
    for (int i = 0; i < nlines; i++) line(scan_rows[i], 640);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.sample_valid = 1'b0; bus.isActive = 1'b0; bus.HS = 1'b1; bus.VS = 1'b1;
    bus.hPix = 10'd700; bus.vPix = 9'd490; bus.sample_in = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("reset_rgb", 32'(bus.rgb), 32'h00);
    chk("reset_hs", 32'(bus.HS_out), 32'h1);
    chk("reset_vs", 32'(bus.VS_out), 32'h1);
    chk("reset_dropped", 32'(bus.dropped), 32'h0);
    chk("reset_swapped", 32'(bus.swapped), 32'h0);
    q_vid.delete();
    q_evt.delete();
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Video has 2-cycle latency, events 1-cycle
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (q_vid.size() >= 2) chk("video", 32'({bus.rgb, bus.HS_out, bus.VS_out}), 32'(q_vid.pop_front()));
      if (q_evt.size() >= 1) chk("events", 32'({bus.dropped, bus.swapped}), 32'(q_evt.pop_front()));
      if (bus.dropped) n_drop++;
      if (bus.swapped) n_swap++;
    end
  end

  initial begin
    bus.sample_valid = 1'b0; bus.sample_in = 8'h00; bus.isActive = 1'b0;
    bus.HS = 1'b1; bus.VS = 1'b1; bus.hPix = 10'd700; bus.vPix = 9'd490;
    model_reset();
    do_reset();

    // Empty display shows the axis only
    frame(8, 1'b0, 8'h00);

    // Flat signal at zero level -> row 239
    n_swap = 0;
    feed(640, 0);
    frame(8, 1'b0, 8'h00);
    chk("flat_swaps", n_swap, 1);

    // Partial capture, reset mid-line, then two sample-free frames
    feed(300, 1);
    frame(2, 1'b0, 8'h00);
    line(241, 100);
    do_reset();
    n_swap = 0;
    frame(8, 1'b0, 8'h00);
    frame(8, 1'b0, 8'h00);
    chk("post_reset_swaps", n_swap, 0);

    // Ramp: columns 0 and 256 at row 367, column 255 at row 112
    feed(640, 1);
    frame(8, 1'b0, 8'h00);

    // Overfill: 60 discarded samples, a single swap
    n_drop = 0; n_swap = 0;
    feed(700, 2);
    frame(8, 1'b0, 8'h00);
    chk("overfill_drops", n_drop, 60);
    chk("overfill_swaps", n_swap, 1);

    // Sample coincident with the swap lands at column 0 of the next bank
    feed(640, 2);
    n_drop = 0;
    frame(8, 1'b1, 8'd126);
    chk("coincident_drops", n_drop, 0);
    feed(639, 2);
    n_swap = 0;
    frame(8, 1'b0, 8'h00);
    chk("coincident_swaps", n_swap, 1);

`ifdef WAVEFORM_RENDERER_FILL_EN
    // Column 0 = 0, column 1 = 255 gives a vertical run from 367 to 112 in column 1
    step(700, 490, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0);
    step(700, 490, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255);
    feed(638, 2);
    frame(8, 1'b0, 8'h00);
`endif

    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
